// File: rtl/pc_unit.sv
// Fetch-stage program counter: trap / redirect / RAS return / stall / sequential next-PC selection.
// Optional return-address stack is built only when PC_RAS_EN is defined.
module pc_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               INC       = 4,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             trap,
  input  logic [WIDTH-1:0] trap_vec,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output logic             misaligned,
  output logic             ras_empty,
  output logic             ras_full
);
  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] ras_top;
  logic             ret_hit;

  assign pc_inc     = pc + INC_W;
  assign misaligned = |pc[1:0];

`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

  logic [RAS_DEPTH-1:0][WIDTH-1:0] ras_mem;
  logic [PW-1:0]                   ras_ptr;
  logic [PW-1:0]                   ptr_up;
  logic [CW-1:0]                   ras_cnt;
  logic                            push, pop;

  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == FULL_CNT);
  assign ptr_up    = ras_ptr + PW'(1);
  assign ras_top   = ras_mem[ras_ptr];
  assign ret_hit   = ret && !stall && !ras_empty;
  assign push      = call && !stall && !trap;
  assign pop       = ret_hit && !trap;

  // ras_ptr indexes the current top; a push lands one slot above it and
  // wraps onto the oldest entry once the stack is full.
  always_ff @(posedge clock) begin
    if (reset || trap) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (push && !pop) begin
      ras_ptr <= ptr_up;
      if (!ras_full) ras_cnt <= ras_cnt + CW'(1);
    end else if (pop && !push) begin
      ras_ptr <= ras_ptr - PW'(1);
      ras_cnt <= ras_cnt - CW'(1);
    end
  end

  // Storage needs no reset; call+ret on a live stack rewrites the top in place.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      if (pop) ras_mem[ras_ptr] <= pc_inc;
      else     ras_mem[ptr_up]  <= pc_inc;
    end
  end
`else
  logic unused_ras;
  assign unused_ras = &{1'b0, call, ret};
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
  assign ras_top    = '0;
  assign ret_hit    = 1'b0;
`endif

  always_comb begin
    pc_next = pc_inc;
    if (trap)          pc_next = trap_vec;
    else if (br_valid) pc_next = br_target;
    else if (ret_hit)  pc_next = ras_top;
    else if (stall)    pc_next = pc;
  end

  always_ff @(posedge clock) begin
    if (reset) pc <= RESET_VEC;
    else       pc <= pc_next;
  end
endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: queue-based reference model checked every cycle, plus directed literal checks.
module tb_pc_unit;
  localparam logic [31:0] RV = 32'h100;
  localparam bit RAS_ON =
`ifdef PC_RAS_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clock = 0, reset = 0, stall = 0, trap = 0, br_valid = 0, call = 0, ret = 0;
  logic [31:0] trap_vec = 0, br_target = 0;
  logic [31:0] pc, pc_next;
  logic        misaligned, ras_empty, ras_full;

  int tests = 0, fails = 0;

  pc_unit #(.WIDTH(32), .RESET_VEC(RV), .INC(4), .RAS_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .stall(stall), .trap(trap), .trap_vec(trap_vec),
    .br_valid(br_valid), .br_target(br_target), .call(call), .ret(ret),
    .pc(pc), .pc_next(pc_next), .misaligned(misaligned),
    .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clock = ~clock;

  // Reference model: PC value plus the return stack as a plain queue (back = top).
  logic [31:0] mpc;
  logic [31:0] mq[$];
  bit          started = 0;

  function automatic bit pop_ok();
    return RAS_ON && ret && !stall && (mq.size() > 0);
  endfunction

  function automatic logic [31:0] exp_next();
    if (trap)          return trap_vec;
    if (br_valid)      return br_target;
    if (pop_ok())      return mq[$];
    if (stall)         return mpc;
    return mpc + 32'd4;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      mpc = RV;
      mq.delete();
      started = 1;
    end else if (started) begin
      logic [31:0] nx;
      nx = exp_next();
      if (trap) mq.delete();
      else if (RAS_ON && call && !stall) begin
        if (pop_ok()) mq[mq.size()-1] = mpc + 32'd4;
        else begin
          mq.push_back(mpc + 32'd4);
          if (mq.size() > 4) void'(mq.pop_front());
        end
      end else if (pop_ok()) void'(mq.pop_back());
      mpc = nx;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (started) begin
      chk("pc", pc, mpc);
      chk("pc_next", pc_next, exp_next());
      chk("misaligned", {31'd0, misaligned}, {31'd0, |mpc[1:0]});
      chk("ras_empty", {31'd0, ras_empty}, {31'd0, (mq.size() == 0)});
      chk("ras_full", {31'd0, ras_full}, {31'd0, (mq.size() == 4)});
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    stall = 0; trap = 0; br_valid = 0; call = 0; ret = 0;
  endtask

  task automatic jump(input logic [31:0] t);
    idle(); br_valid = 1; br_target = t; step(); idle();
  endtask

  logic [31:0] exp_ret[4];
  logic [31:0] after_empty;

  initial begin
    reset = 1; step(); step(); reset = 0; idle();
    chk("lit_reset_pc", pc, 32'h100);
    chk("lit_reset_empty", {31'd0, ras_empty}, 32'd1);
    chk("lit_reset_full", {31'd0, ras_full}, 32'd0);
    step(); chk("lit_seq1", pc, 32'h104);
    step(); chk("lit_seq2", pc, 32'h108);
    chk("lit_seq3_next", pc_next, 32'h10C);

    // redirect beats stall, then stall holds
    stall = 1; br_valid = 1; br_target = 32'h200; step();
    chk("lit_br_over_stall", pc, 32'h200);
    br_valid = 0; step();
    chk("lit_stall_hold", pc, 32'h200);

    jump(32'h202);
    chk("lit_misaligned", {31'd0, misaligned}, 32'd1);

    // call at 0x40 redirected to 0x80, return from 0x88
    jump(32'h40);
    call = 1; br_valid = 1; br_target = 32'h80; step(); idle();
    step(); step();
    chk("lit_at_88", pc, 32'h88);
    ret = 1; step(); idle();
    chk("lit_ret_target", pc, RAS_ON ? 32'h44 : 32'h8C);
    chk("lit_ret_empty", {31'd0, ras_empty}, 32'd1);

    // five calls into a four-deep stack, then drain
    jump(32'h10);
    for (int i = 0; i < 5; i++) begin
      call = 1; br_valid = (i < 4); br_target = 32'h20 + 32'h10 * i; step();
      if (i == 3) chk("lit_full_after4", {31'd0, ras_full}, {31'd0, RAS_ON});
    end
    idle();
    chk("lit_full_after5", {31'd0, ras_full}, {31'd0, RAS_ON});
    if (RAS_ON) begin
      exp_ret = '{32'h54, 32'h44, 32'h34, 32'h24}; after_empty = 32'h28;
    end else begin
      exp_ret = '{32'h58, 32'h5C, 32'h60, 32'h64}; after_empty = 32'h68;
    end
    for (int i = 0; i < 4; i++) begin
      ret = 1; step();
      chk("lit_ret_order", pc, exp_ret[i]);
    end
    step(); idle();
    chk("lit_ret_on_empty", pc, after_empty);

    // trap clears a two-entry stack; top-of-range wraps to zero
    jump(32'h300);
    call = 1; br_valid = 1; br_target = 32'h400; step();
    call = 1; br_valid = 1; br_target = 32'hFFFFFFFC; step(); idle();
    chk("lit_two_entries", {31'd0, ras_empty}, {31'd0, !RAS_ON});
    trap = 1; trap_vec = 32'hFFC; step(); idle();
    chk("lit_trap_pc", pc, 32'hFFC);
    chk("lit_trap_empty", {31'd0, ras_empty}, 32'd1);
    jump(32'hFFFFFFFC);
    step();
    chk("lit_wrap", pc, 32'h0);

    // randomized traffic, checked by the every-cycle compare
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom % 250) == 0;
      trap      = ($urandom % 25) == 0;
      br_valid  = ($urandom % 6) == 0;
      call      = ($urandom % 4) == 0;
      ret       = ($urandom % 3) == 0;
      stall     = ($urandom % 5) == 0;
      trap_vec  = $urandom & 32'hFFFF_FFFC;
      br_target = (($urandom % 8) == 0) ? $urandom : (($urandom % 4) == 0 ? 32'hFFFF_FFF0 : $urandom & 32'hFFFF_FFFC);
      step();
    end
    reset = 0; idle(); step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the Simple_CPU fetch stage. It holds the fetch PC and computes the next PC each cycle from several sources in a fixed priority: trap vector, branch/jump redirect, return-address pop, stall hold, or sequential increment. An optional circular return-address stack (RAS) supplies return targets without waiting for register read.

## Interface

- WIDTH, 32, PC width in bits
- RESET_VEC, 0, PC value loaded on reset (WIDTH bits)
- INC, 4, sequential increment
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- stall  in  1  hold PC; suppresses call/ret
- trap  in  1  take trap this cycle
- trap_vec  in  WIDTH  trap target
- br_valid  in  1  redirect this cycle
- br_target  in  WIDTH  redirect target
- call  in  1  current instruction is a call; push pc+INC
- ret  in  1  current instruction is a return; pop RAS
- pc  out  WIDTH  current fetch PC (registered)
- pc_next  out  WIDTH  value pc takes at next edge (combinational)
- misaligned  out  1  |pc[1:0], combinational
- ras_empty  out  1  RAS count == 0
- ras_full  out  1  RAS count == RAS_DEPTH

## Operation

- Next-PC priority, highest first: trap → trap_vec; br_valid → br_target; ret && !stall && !ras_empty → RAS top; stall → pc; else pc+INC.
- Arithmetic: pc+INC is modulo 2^WIDTH; all-ones region wraps to low addresses without flag.
- trap and br_valid override stall.
- Push: call && !stall && !trap writes pc+INC (not pc_next) at top+1; count increments.
- Pop: ret && !stall && !trap && !ras_empty; count decrements.
- ret on empty RAS: no pop, PC follows lower-priority sources (sequential or stall).
- call and ret together (RAS non-empty): top entry overwritten with pc+INC, count unchanged; next PC is old top unless trap/br_valid.
- call and ret together (RAS empty): plain push.
- Push when full: circular overwrite of oldest entry; count stays RAS_DEPTH; ras_full stays 1.
- trap clears RAS: count=0, pointer=0; entries need not be cleared.
- br_valid with ret: br_target wins for PC, pop still happens.
- misaligned is informational only; PC is never realigned.

## Timing

- Reset (synchronous): pc=RESET_VEC, count=0, pointer=0, ras_empty=1, ras_full=0, misaligned=|RESET_VEC[1:0].
- reset overrides all inputs on the same edge, including mid-push/pop.
- Redirect latency: one cycle; inputs sampled at edge N appear on pc after edge N.
- pc_next is valid combinationally in the same cycle as its inputs; pc equals previous-cycle pc_next.
- RAS push/pop take effect at the same edge as the PC update; a pop in the cycle after a push returns the pushed value.
- All inputs are level-sampled; no handshake, no back-pressure toward the source.

## Configuration

- PC_RAS_EN defined: RAS storage, pointer and count built; call/ret behave as above.
- PC_RAS_EN undefined: no RAS storage; call and ret ignored; ret falls through to stall/sequential; ras_empty tied 1, ras_full tied 0.

## Test plan

- Reset then 3 free-run cycles, RESET_VEC=0x100 → pc 0x100, 0x104, 0x108, 0x10C.
- stall=1 at pc=0x108 with br_valid=1, br_target=0x200 → pc 0x200 next cycle; stall alone → pc held at 0x200.
- call at pc=0x40 with br_valid to 0x80, then ret at pc=0x88 → pc 0x44 after ret; ras_empty=1 afterwards.
- 5 calls (RAS_DEPTH=4) from pc 0x10,0x20,0x30,0x40,0x50 then 4 rets → return order 0x54,0x44,0x34,0x24; ras_full=1 after 4th call; ret on empty → sequential increment.
- trap with trap_vec=0xFFC at pc=0xFFFFFFFC, RAS holding 2 entries → pc 0xFFC, ras_empty=1; from pc=0xFFFFFFFC sequential → 0x0.
- br_target=0x202 → misaligned=1 next cycle; with PC_RAS_EN undefined, ret at pc=0x10 → pc 0x14.
